// File: rtl/xvc_jtag_shift_engine.sv
// JTAG shift engine for the XVC "shift:"/"settck:" operations: streams TMS/TDI words
// out on TCK at a programmable rate and returns the captured TDO words.
module xvc_jtag_shift_engine #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 32,
  parameter int DIV_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_half_period,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_nbits,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_tms,
  input  logic [WORD_W-1:0] in_tdi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_tdo,
  output logic              busy,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, EMIT} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    rem_reg, rem_next;
  logic [DIV_W-1:0]    half_reg, half_next;
  logic [DIV_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IDX_W-1:0]    idx_inc;
  logic [WORD_W-1:0]   tms_word_reg, tms_word_next;
  logic [WORD_W-1:0]   tdi_word_reg, tdi_word_next;
  logic [WORD_W-1:0]   tdo_reg, tdo_next;
  logic                tck_reg, tck_next;
  logic                tms_reg, tms_next;
  logic                tdi_reg, tdi_next;
  logic                busy_reg, busy_next;

  assign idx_inc   = idx_reg + 1'b1;
  assign cmd_ready = (state_reg == IDLE);
  assign in_ready  = (state_reg == LOAD);
  assign out_valid = (state_reg == EMIT);
  assign out_tdo   = tdo_reg;
  assign busy      = busy_reg;
  assign jtag_tck  = tck_reg;
  assign jtag_tms  = tms_reg;
  assign jtag_tdi  = tdi_reg;

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    half_next     = half_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    tms_word_next = tms_word_reg;
    tdi_word_next = tdi_word_reg;
    tdo_next      = tdo_reg;
    tck_next      = tck_reg;
    tms_next      = tms_reg;
    tdi_next      = tdi_reg;
    busy_next     = busy_reg;

    case (state_reg)
      IDLE: begin
        // A zero-length shift is simply swallowed here.
        if (cmd_valid && (cmd_nbits != '0)) begin
          rem_next   = cmd_nbits;
          half_next  = cfg_half_period;
          busy_next  = 1'b1;
          tdo_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          tms_word_next = in_tms;
          tdi_word_next = in_tdi;
          idx_next      = '0;
          cnt_next      = '0;
          tms_next      = in_tms[0];
          tdi_next      = in_tdi[0];
          state_next    = LOW;
        end
      end
      LOW: begin
        if (cnt_reg == half_reg) begin
          cnt_next          = '0;
          tck_next          = 1'b1;
          tdo_next[idx_reg] = jtag_tdo;
          state_next        = HIGH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (cnt_reg == half_reg) begin
          cnt_next = '0;
          tck_next = 1'b0;
          rem_next = rem_reg - 1'b1;
          idx_next = idx_inc;
          if ((rem_reg == LEN_W'(1)) || (idx_reg == IDX_W'(WORD_W - 1))) begin
            state_next = EMIT;
          end else begin
            // New bit is presented on the falling TCK edge.
            tms_next   = tms_word_reg[idx_inc];
            tdi_next   = tdi_word_reg[idx_inc];
            state_next = LOW;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (rem_reg != '0) begin
            tdo_next   = '0;
            state_next = LOAD;
          end else begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      half_reg     <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      tms_word_reg <= '0;
      tdi_word_reg <= '0;
      tdo_reg      <= '0;
      tck_reg      <= 1'b0;
      tms_reg      <= 1'b0;
      tdi_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      half_reg     <= half_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      tms_word_reg <= tms_word_next;
      tdi_word_reg <= tdi_word_next;
      tdo_reg      <= tdo_next;
      tck_reg      <= tck_next;
      tms_reg      <= tms_next;
      tdi_reg      <= tdi_next;
      busy_reg     <= busy_next;
    end
  end

endmodule

// File: tb/tb_xvc_jtag_shift_engine.sv
// Self-checking bench for xvc_jtag_shift_engine: directed cases plus randomized
// shifts compared against a bit-level reference model.
module tb_xvc_jtag_shift_engine;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 32;
  localparam int DIV_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [DIV_W-1:0]  cfg_half_period = '0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_nbits = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_tms = '0;
  logic [WORD_W-1:0] in_tdi = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_tdo;
  logic              busy;
  logic              jtag_tck;
  logic              jtag_tms;
  logic              jtag_tdi;
  logic              jtag_tdo;

  int tdo_mode = 0;  // 0: TDO = TDI loopback, 1: TDO = TMS ^ TDI
  assign jtag_tdo = (tdo_mode == 1) ? (jtag_tms ^ jtag_tdi) : jtag_tdi;

  xvc_jtag_shift_engine #(.WORD_W(WORD_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .cfg_half_period(cfg_half_period),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_nbits(cmd_nbits),
    .in_valid(in_valid), .in_ready(in_ready), .in_tms(in_tms), .in_tdi(in_tdi),
    .out_valid(out_valid), .out_ready(out_ready), .out_tdo(out_tdo), .busy(busy),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );

  always #5 clock = ~clock;

  // TCK edge monitor: records cycle stamps and TMS/TDI values at each rising edge.
  int   cyc = 0;
  logic tck_prev = 1'b0;
  int   rise_q[$];
  int   fall_q[$];
  logic tms_q[$];
  logic tdi_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (jtag_tck && !tck_prev) begin
      rise_q.push_back(cyc);
      tms_q.push_back(jtag_tms);
      tdi_q.push_back(jtag_tdi);
    end
    if (!jtag_tck && tck_prev) fall_q.push_back(cyc);
    tck_prev <= jtag_tck;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [WORD_W-1:0] tms_w [4];
  logic [WORD_W-1:0] tdi_w [4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    tms_q.delete();
    tdi_q.delete();
  endtask

  // Reference: TDO bit k equals the TDI bit (xor TMS in mode 1); bits past nbits are 0.
  function automatic logic [WORD_W-1:0] exp_word(int w, int nbits, int mode);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_W; b++)
      if (w * WORD_W + b < nbits)
        r[b] = tdi_w[w][b] ^ ((mode == 1) ? tms_w[w][b] : 1'b0);
    return r;
  endfunction

  task automatic wait_in_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, " in_ready timeout"}, 128'(ok), 128'(1));
  endtask

  task automatic wait_out_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, " out_valid timeout"}, 128'(ok), 128'(1));
  endtask

  // Runs one complete shift command starting and ending on a falling clock edge.
  task automatic run_shift(input string tag, input int h, input int nbits, input int mode,
                           input bit stall_first);
    int nwords;
    bit ok;
    int hi_bad;
    int sp_bad;
    logic [127:0] obs_tms, exp_tms, obs_tdi, exp_tdi;
    nwords = (nbits + WORD_W - 1) / WORD_W;
    tdo_mode = mode;
    clear_mon();
    check({tag, " cmd_ready idle"}, 128'(cmd_ready), 128'(1));
    cfg_half_period = DIV_W'(h);
    cmd_nbits = LEN_W'(nbits);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cfg_half_period = DIV_W'(h + 1 + $urandom_range(0, 4));
    check({tag, " busy set"}, 128'(busy), 128'(1));
    for (int w = 0; w < nwords; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      wait_in_ready(tag, ok);
      if (!ok) return;
      in_valid = 1'b1;
      in_tms = tms_w[w];
      in_tdi = tdi_w[w];
      @(negedge clock);
      in_valid = 1'b0;
      in_tms = $urandom;
      in_tdi = $urandom;
      wait_out_valid(tag, ok);
      if (!ok) return;
      if (w == 0 && stall_first) begin
        repeat (10) begin
          check({tag, " tck low in stall"}, 128'(jtag_tck), 128'(0));
          @(negedge clock);
        end
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      check($sformatf("%s out_tdo[%0d]", tag, w), 128'(out_tdo), 128'(exp_word(w, nbits, mode)));
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 128'(out_valid), 128'(0));
    end
    check({tag, " busy clear"}, 128'(busy), 128'(0));
    check({tag, " tck rising count"}, 128'(rise_q.size()), 128'(nbits));
    obs_tms = '0; exp_tms = '0; obs_tdi = '0; exp_tdi = '0;
    for (int k = 0; k < nbits && k < 128; k++) begin
      exp_tms[k] = tms_w[k / WORD_W][k % WORD_W];
      exp_tdi[k] = tdi_w[k / WORD_W][k % WORD_W];
      if (k < tms_q.size()) begin
        obs_tms[k] = tms_q[k];
        obs_tdi[k] = tdi_q[k];
      end
    end
    check({tag, " tms sequence"}, obs_tms, exp_tms);
    check({tag, " tdi sequence"}, obs_tdi, exp_tdi);
    hi_bad = 0;
    sp_bad = 0;
    for (int k = 0; k < rise_q.size() && k < fall_q.size(); k++)
      if (fall_q[k] - rise_q[k] != h + 1) hi_bad++;
    for (int k = 0; k + 1 < rise_q.size(); k++)
      if (((k + 1) % WORD_W) != 0 && (rise_q[k + 1] - rise_q[k] != 2 * (h + 1))) sp_bad++;
    check({tag, " tck high width errors"}, 128'(hi_bad), 128'(0));
    check({tag, " tck period errors"}, 128'(sp_bad), 128'(0));
  endtask

  initial begin
    bit ok;
    bit seen;
    int nb;
    int h;
    int mode;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst in_ready", 128'(in_ready), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_tdo", 128'(out_tdo), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst tck", 128'(jtag_tck), 128'(0));
    check("rst tms", 128'(jtag_tms), 128'(0));
    check("rst tdi", 128'(jtag_tdi), 128'(0));
    reset = 1'b1;
    @(negedge clock);

    // 8-bit loopback
    tms_w[0] = 32'h0000_0055;
    tdi_w[0] = 32'h0000_00A5;
    run_shift("t1", 0, 8, 0, 1'b0);

    // 40 bits across two words
    tms_w[0] = 32'h0; tms_w[1] = 32'h0;
    tdi_w[0] = 32'hDEAD_BEEF;
    tdi_w[1] = 32'h0000_0012;
    run_shift("t2", 0, 40, 0, 1'b0);

    // Slow TCK with mid-command half-period change
    tms_w[0] = 32'h0000_0009;
    tdi_w[0] = 32'h0000_0006;
    run_shift("t3", 3, 4, 1, 1'b0);

    // Output stall at first EMIT
    tms_w[0] = $urandom; tms_w[1] = $urandom;
    tdi_w[0] = $urandom; tdi_w[1] = $urandom;
    run_shift("t4", 0, 64, 0, 1'b1);

    // Zero-length command
    clear_mon();
    cmd_nbits = '0;
    cmd_valid = 1'b1;
    check("t5 cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge clock);
    cmd_valid = 1'b0;
    check("t5 busy", 128'(busy), 128'(0));
    check("t5 cmd_ready after", 128'(cmd_ready), 128'(1));
    seen = 1'b0;
    repeat (8) begin
      if (in_ready || out_valid || jtag_tck) seen = 1'b1;
      @(negedge clock);
    end
    check("t5 no activity", 128'(seen), 128'(0));
    check("t5 no tck edge", 128'(rise_q.size()), 128'(0));

    // Reset in the middle of a 32-bit shift
    clear_mon();
    tdo_mode = 0;
    cfg_half_period = '0;
    cmd_nbits = 32'd32;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_in_ready("t6", ok);
    in_valid = 1'b1;
    in_tms = $urandom;
    in_tdi = $urandom;
    @(negedge clock);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rise_q.size() >= 5) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check("t6 reached bit 5", 128'(ok), 128'(1));
    reset = 1'b0;
    @(negedge clock);
    check("t6 tck", 128'(jtag_tck), 128'(0));
    check("t6 busy", 128'(busy), 128'(0));
    check("t6 out_valid", 128'(out_valid), 128'(0));
    check("t6 cmd_ready", 128'(cmd_ready), 128'(1));
    check("t6 in_ready", 128'(in_ready), 128'(0));
    check("t6 out_tdo", 128'(out_tdo), 128'(0));
    reset = 1'b1;
    @(negedge clock);
    tms_w[0] = 32'h0000_00C3;
    tdi_w[0] = 32'h0000_003C;
    run_shift("t6 follow", 0, 8, 0, 1'b0);

    // Randomized commands
    for (int t = 0; t < 8; t++) begin
      nb = $urandom_range(1, 128);
      h = $urandom_range(0, 3);
      mode = $urandom_range(0, 1);
      for (int w = 0; w < 4; w++) begin
        tms_w[w] = $urandom;
        tdi_w[w] = $urandom;
      end
      run_shift($sformatf("rnd%0d", t), h, nb, mode, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xvc_jtag_shift_engine.md
Name: xvc_jtag_shift_engine

Overview:
Parametrised JTAG shift engine that executes the XVC "shift:" and "settck:" operations in hardware.
- Takes a bit count plus TMS/TDI words over a valid/ready stream.
- Drives TCK/TMS/TDI at a runtime-programmable TCK rate and returns captured TDO words over a second valid/ready stream.
- Sits between the microserver's packet/command layer and the target JTAG pins.

Parameters:
WORD_W, 32, width of TMS/TDI/TDO stream words; bits are consumed LSB first.
LEN_W, 32, width of the shift bit-count field.
DIV_W, 16, width of the TCK half-period setting.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
cfg_half_period  input  DIV_W  TCK half-period minus 1, in clock cycles; sampled on command accept.
cmd_valid  input  1  shift command valid.
cmd_ready  output  1  engine can accept a command.
cmd_nbits  input  LEN_W  number of TCK cycles to shift.
in_valid  input  1  TMS/TDI word valid.
in_ready  output  1  engine accepts a TMS/TDI word.
in_tms  input  WORD_W  TMS bits.
in_tdi  input  WORD_W  TDI bits.
out_valid  output  1  TDO word valid.
out_ready  input  1  consumer accepts the TDO word.
out_tdo  output  WORD_W  captured TDO bits, LSB = first bit.
busy  output  1  command in progress.
jtag_tck  output  1  JTAG clock.
jtag_tms  output  1  JTAG TMS.
jtag_tdi  output  1  JTAG TDI.
jtag_tdo  input  1  JTAG TDO, already synchronised by the caller.

Behaviour:
- Reset values (reset=0 sampled on a rising edge):
  - cmd_ready=1; in_ready=0; out_valid=0; out_tdo=0; busy=0; jtag_tck=0; jtag_tms=0; jtag_tdi=0.
  - State returns to IDLE.
  - Any command in progress is aborted and its partial TDO data is discarded.
- H = latched cfg_half_period. TCK low phase = H+1 clocks and high phase = H+1 clocks, so the TCK period is 2(H+1) clocks.
- IDLE:
  - cmd_ready=1.
  - cmd_valid with cmd_nbits=0: accepted; stays in IDLE; no TCK edge and no output word.
  - cmd_valid with cmd_nbits>0: latch nbits and H, set busy=1, go to LOAD.
- LOAD:
  - in_ready=1 and cmd_ready=0.
  - On the in handshake, latch the TMS/TDI word and set the in-word bit index to 0. Go to LOW.
  - jtag_tck stays 0 while in_valid is low.
- LOW:
  - jtag_tms/jtag_tdi carry the current bit from the first LOW cycle, i.e. one clock after the in handshake for bit 0.
  - TCK stays 0 for H+1 clocks.
  - jtag_tdo is captured into bit[index] of the TDO shift register on the last LOW cycle, the same edge on which jtag_tck goes to 1.
  - Go to HIGH.
- HIGH:
  - TCK stays 1 for H+1 clocks; on the last cycle TCK returns to 0.
  - Decrement the remaining count and increment the index.
  - If remaining=0 or index=WORD_W, go to EMIT; otherwise go to LOW with the next bit.
- EMIT:
  - out_valid=1 with out_tdo = the captured word. In a partial final word, unused upper bits are 0.
  - TCK is held at 0 while out_ready is low; no extra TCK edges are produced.
  - On the handshake: if remaining>0, clear the TDO register and go to LOAD. Otherwise clear busy and go to IDLE.
  - out_valid drops the cycle after the handshake.
- Word counts: in words = out words = ceil(nbits/WORD_W). TCK rising edges = nbits exactly.
- jtag_tms/jtag_tdi hold their last driven value between commands.
- cfg_half_period changes during a command have no effect until the next accept.
- Counters are LEN_W/DIV_W wide and must not wrap: the maximum nbits is 2^LEN_W-1 and the maximum H is 2^DIV_W-1.

Test Plan:
1. H=0, nbits=8, in_tms=0x00000055, in_tdi=0x000000A5, jtag_tdo looped to jtag_tdi -> 8 TCK rising edges with period 2 clocks; TMS sequence 1,0,1,0,1,0,1,0; out_tdo=0x000000A5; busy returns to 0.
2. H=0, nbits=40, two in words with in_tdi=0xDEADBEEF then 0x00000012, loopback -> out words 0xDEADBEEF then 0x00000012 (upper 24 bits 0); 40 TCK edges.
3. H=3, nbits=4 -> TCK high for 4 clocks and low for 4 clocks (period 8); cfg_half_period changed mid-command has no effect on this command.
4. H=0, nbits=64, out_ready held low for 10 clocks at the first EMIT -> jtag_tck stays 0 during the stall; total rising edges=64; data intact.
5. cmd_nbits=0 -> accepted in 1 cycle; no TCK edge; no in_ready and no out_valid; busy stays 0.
6. Drive reset=0 mid-shift at bit 5 of 32 -> on the next clock jtag_tck=0, busy=0, out_valid=0, cmd_ready=1; a following 8-bit command completes normally.
